// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg: shared types and constants for the halfword realignment
// buffer.
//   halfword_t            - one 16-bit instruction parcel
//   OPC_32BIT             - low opcode bits marking a 32-bit instruction
//   fetch_align_in_type   - control fields of the fetch side
//   fetch_align_out_type  - aligned instruction presented to decode
package fetch_align_pkg;

  typedef logic [15:0] halfword_t;

  localparam logic [1:0] OPC_32BIT = 2'b11;

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic [31:0] flush_addr;
  } fetch_align_in_type;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        illegal;
  } fetch_align_out_type;

  // RVC length rule: anything other than 2'b11 in the low bits is 16-bit.
  function automatic logic is_comp(input halfword_t h);
    return h[1:0] != OPC_32BIT;
  endfunction

endpackage

// File: rtl/fetch_align_if.sv
// fetch_align_if: fetch-side and decode-side handshake bundle.
//   fetch_valid/fetch_ready/fetch_data : fetch beats into the buffer
//   flush/flush_addr                   : redirect request
//   instr_valid/instr_ready            : aligned instruction handshake
//   instr/instr_pc/instr_comp/instr_illegal : instruction payload
// master = fetch unit + decode (bench), slave = fetch_align.
interface fetch_align_if #(
  parameter int FETCH_BYTES = 4
);
  logic                     fetch_valid;
  logic                     fetch_ready;
  logic [8*FETCH_BYTES-1:0] fetch_data;
  logic                     flush;
  logic [31:0]              flush_addr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [31:0]              instr;
  logic [31:0]              instr_pc;
  logic                     instr_comp;
  logic                     instr_illegal;

  modport master (
    output fetch_valid, fetch_data, flush, flush_addr, instr_ready,
    input  fetch_ready, instr_valid, instr, instr_pc, instr_comp, instr_illegal
  );

  modport slave (
    input  fetch_valid, fetch_data, flush, flush_addr, instr_ready,
    output fetch_ready, instr_valid, instr, instr_pc, instr_comp, instr_illegal
  );
endinterface

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: DEPTH x 16 ring storage.
//   clock   - system clock
//   we      - write enable
//   wr_ptr  - slot of the first halfword written
//   wr_cnt  - number of halfwords written (lanes 0..wr_cnt-1 of wr_data)
//   wr_data - FETCH_HW halfwords, lane 0 lands at wr_ptr
//   rd_ptr  - head slot
//   h0/h1   - halfwords at rd_ptr and rd_ptr+1
// Storage carries no reset; validity is tracked by the owner's count.
module fetch_align_buffer
  import fetch_align_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int FETCH_HW = 2,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [CNT_W-1:0]      wr_cnt,
  input  logic [16*FETCH_HW-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_ptr,
  output halfword_t             h0,
  output halfword_t             h1
);

  halfword_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < FETCH_HW; i++) begin
        if (CNT_W'(i) < wr_cnt) begin
          mem[wr_ptr + PTR_W'(i)] <= wr_data[16*i +: 16];
        end
      end
    end
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign h0 = mem[rd_ptr];
  assign h1 = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/fetch_align.sv
// fetch_align: halfword realignment buffer between fetch and decode.
//   clock - system clock
//   reset - asynchronous reset, active-low
//   bus   - fetch_align_if slave: fetch beats in, aligned instructions out,
//           flush/flush_addr redirect
// Beats are stored as halfwords; the head presents a 16-bit compressed or a
// 32-bit (possibly beat-straddling) instruction together with its PC.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter int          FETCH_BYTES = 4,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] RESET_ADDR  = 32'h0,
  parameter int          C_EXT       = 1
) (
  input logic          clock,
  input logic          reset,
  fetch_align_if.slave bus
);

  localparam int FETCH_HW = FETCH_BYTES / 2;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int SKIP_W   = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
  localparam int BEAT_W   = 8 * FETCH_BYTES;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       pc_reg;
  logic              first_beat;

  fetch_align_in_type  in_s;
  fetch_align_out_type out_s;

  logic [SKIP_W-1:0] skip;
  logic [CNT_W-1:0]  wr_cnt;
  logic [BEAT_W-1:0] wr_data;
  logic              fetch_ready;
  logic              push;
  logic              pop;
  logic              comp;
  logic [CNT_W-1:0]  need;
  halfword_t         h0;
  halfword_t         h1;

  assign in_s = '{valid: bus.fetch_valid, flush: bus.flush, flush_addr: bus.flush_addr};

  // Only the first beat after reset/redirect can start mid-beat; the halfwords
  // below the target PC are shifted out so lane 0 is the target halfword.
  assign skip    = first_beat ? pc_reg[SKIP_W:1] : '0;
  assign wr_cnt  = CNT_W'(FETCH_HW) - CNT_W'(skip);
  assign wr_data = bus.fetch_data >> {skip, 4'b0000};

  assign fetch_ready = !in_s.flush && (count <= CNT_W'(DEPTH - FETCH_HW));
  assign push        = in_s.valid && fetch_ready;

  fetch_align_buffer #(
    .DEPTH    (DEPTH),
    .FETCH_HW (FETCH_HW),
    .PTR_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_buffer (
    .clock   (clock),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .h0      (h0),
    .h1      (h1)
  );

  assign comp = is_comp(h0);
  assign need = comp ? CNT_W'(1) : CNT_W'(2);
  assign pop  = out_s.valid && bus.instr_ready;

  // Payload is forced to zero while the buffer is empty so the unreset
  // storage never leaks onto the outputs.
  always_comb begin
    out_s         = '0;
    out_s.valid   = !in_s.flush && (count >= need);
    out_s.pc      = pc_reg;
    if (count != '0) begin
      out_s.instr   = comp ? {16'h0000, h0} : {h1, h0};
      out_s.comp    = comp;
      out_s.illegal = comp && (C_EXT == 0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pc_reg     <= RESET_ADDR;
      first_beat <= 1'b1;
    end else if (in_s.flush) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pc_reg     <= in_s.flush_addr & 32'hFFFF_FFFE;
      first_beat <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(wr_cnt);
        first_beat <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(need);
        pc_reg <= pc_reg + (32'(need) << 1);
      end
      count <= count + (push ? wr_cnt : '0) - (pop ? need : '0);
    end
  end

  assign bus.fetch_ready   = fetch_ready;
  assign bus.instr_valid   = out_s.valid;
  assign bus.instr         = out_s.instr;
  assign bus.instr_pc      = out_s.pc;
  assign bus.instr_comp    = out_s.comp;
  assign bus.instr_illegal = out_s.illegal;

endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: scoreboard bench for fetch_align. Two instances (RVC
// accepted / RVC illegal) are driven identically. A stream model parses the
// accepted halfwords into expected instructions; a negedge monitor compares.
module tb_fetch_align;

  localparam int          FB   = 4;
  localparam int          HW   = FB / 2;
  localparam int          DEP  = 8;
  localparam logic [31:0] RST  = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_data = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = '0;
  logic        instr_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_align_if #(.FETCH_BYTES(FB)) a_if ();
  fetch_align_if #(.FETCH_BYTES(FB)) b_if ();

  assign a_if.fetch_valid = fetch_valid;
  assign a_if.fetch_data  = fetch_data;
  assign a_if.flush       = flush;
  assign a_if.flush_addr  = flush_addr;
  assign a_if.instr_ready = instr_ready;
  assign b_if.fetch_valid = fetch_valid;
  assign b_if.fetch_data  = fetch_data;
  assign b_if.flush       = flush;
  assign b_if.flush_addr  = flush_addr;
  assign b_if.instr_ready = instr_ready;

  fetch_align #(.FETCH_BYTES(FB), .DEPTH(DEP), .RESET_ADDR(RST), .C_EXT(1))
    dut_a (.clock(clock), .reset(reset), .bus(a_if));
  fetch_align #(.FETCH_BYTES(FB), .DEPTH(DEP), .RESET_ADDR(RST), .C_EXT(0))
    dut_b (.clock(clock), .reset(reset), .bus(b_if));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          comp;
    int          hw;
  } exp_t;

  logic [15:0] pend[$];
  exp_t        expq[$];
  int          cnt = 0;
  int          popped_hw = 0;
  logic [31:0] mpc = RST;
  logic [31:0] ppc = RST;
  bit          first = 1'b1;

  task automatic parse();
    exp_t e;
    while (pend.size() > 0) begin
      if (pend[0][1:0] != 2'b11) begin
        e = '{instr: {16'h0, pend[0]}, pc: ppc, comp: 1'b1, hw: 1};
        void'(pend.pop_front());
      end else if (pend.size() >= 2) begin
        e = '{instr: {pend[1], pend[0]}, pc: ppc, comp: 1'b0, hw: 2};
        void'(pend.pop_front());
        void'(pend.pop_front());
      end else begin
        break;
      end
      ppc = ppc + 32'(2 * e.hw);
      expq.push_back(e);
    end
  endtask

  task automatic model_clear(input logic [31:0] pc);
    pend.delete();
    expq.delete();
    cnt = 0;
    popped_hw = 0;
    mpc = pc;
    ppc = pc;
    first = 1'b1;
  endtask

  always @(posedge clock) begin
    int pushed;
    int sk;
    if (!reset) begin
      model_clear(RST);
    end else if (flush) begin
      model_clear(flush_addr & 32'hFFFF_FFFE);
    end else begin
      pushed = 0;
      if (fetch_valid && cnt <= DEP - HW) begin
        sk = first ? int'((mpc % FB) / 2) : 0;
        for (int i = sk; i < HW; i++) pend.push_back(fetch_data[16*i +: 16]);
        pushed = HW - sk;
        first = 1'b0;
        parse();
      end
      mpc = mpc + 32'(2 * popped_hw);
      cnt = cnt + pushed - popped_hw;
      popped_hw = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    bit ev;
    bit er;
    if (!reset) begin
      chk("rst_valid", 32'(a_if.instr_valid), 0);
      chk("rst_ready", 32'(a_if.fetch_ready), 1);
      chk("rst_pc", a_if.instr_pc, RST);
      chk("rst_instr", a_if.instr, 0);
      chk("rst_comp", 32'(a_if.instr_comp), 0);
      chk("rst_illegal", 32'(a_if.instr_illegal), 0);
      chk("rst_b_valid", 32'(b_if.instr_valid), 0);
      chk("rst_b_pc", b_if.instr_pc, RST);
    end else begin
      ev = !flush && (expq.size() > 0);
      er = !flush && (cnt <= DEP - HW);
      chk("valid", 32'(a_if.instr_valid), 32'(ev));
      chk("b_valid", 32'(b_if.instr_valid), 32'(ev));
      chk("fetch_ready", 32'(a_if.fetch_ready), 32'(er));
      chk("b_fetch_ready", 32'(b_if.fetch_ready), 32'(er));
      chk("pc", a_if.instr_pc, mpc);
      chk("b_pc", b_if.instr_pc, mpc);
      if (ev) begin
        chk("instr", a_if.instr, expq[0].instr);
        chk("instr_pc_head", a_if.instr_pc, expq[0].pc);
        chk("comp", 32'(a_if.instr_comp), 32'(expq[0].comp));
        chk("illegal", 32'(a_if.instr_illegal), 0);
        chk("b_instr", b_if.instr, expq[0].instr);
        chk("b_comp", 32'(b_if.instr_comp), 32'(expq[0].comp));
        chk("b_illegal", 32'(b_if.instr_illegal), 32'(expq[0].comp));
        if (instr_ready) begin
          popped_hw = expq[0].hw;
          void'(expq.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bit ok = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = a_if.fetch_ready;
      @(posedge clock);
      #1;
    end
    fetch_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush = 1'b1;
    flush_addr = a;
    step(1);
    flush = 1'b0;
  endtask

  initial begin
    int nacc;
    step(3);
    reset = 1'b1;
    step(1);

    // 32-bit instructions
    instr_ready = 1'b1;
    do_flush(32'h100);
    send(32'h0013_0013);
    send(32'h00A0_0093);
    step(4);

    // two compressed instructions in one beat
    do_flush(32'h200);
    send(32'h4505_0505);
    step(4);

    // straddling 32-bit instruction, second beat delayed
    send(32'h0093_4505);
    step(3);
    send(32'h0000_00A0);
    step(4);

    // redirect to odd halfword: low halfword dropped
    do_flush(32'h302);
    send(32'h0505_FFFF);
    step(4);

    // backpressure: fill with instr_ready low
    do_flush(32'h400);
    instr_ready = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = 32'h0013_0013;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (a_if.fetch_ready) nacc++;
      @(posedge clock);
      #1;
    end
    chk("bp_beats", 32'(nacc), 4);

    // flush with concurrent beat and pop
    instr_ready = 1'b1;
    flush = 1'b1;
    flush_addr = 32'h0000_0511;
    step(1);
    flush = 1'b0;
    fetch_valid = 1'b0;
    chk("flush_pc", a_if.instr_pc, 32'h0000_0510);
    chk("flush_valid", 32'(a_if.instr_valid), 0);
    step(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] lo;
      logic [15:0] hi;
      lo = 16'($urandom);
      hi = 16'($urandom);
      if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
      fetch_valid = ($urandom_range(0, 9) < 7);
      fetch_data  = {hi, lo};
      instr_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      flush_addr  = $urandom();
      step(1);
    end
    fetch_valid = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b1;
    step(10);
    chk("drain_empty", 32'(expq.size()), 0);

    // asynchronous reset mid-stream
    instr_ready = 1'b0;
    send(32'h0013_0013);
    chk("pre_reset_valid", 32'(a_if.instr_valid), 1);
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(a_if.instr_valid), 0);
    chk("async_pc", a_if.instr_pc, RST);
    step(2);
    reset = 1'b1;
    step(1);

    // compressed pair: illegal on the C_EXT=0 instance
    instr_ready = 1'b1;
    send(32'h0001_0001);
    step(4);
    chk("rvc_pc_end", a_if.instr_pc, RST + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Halfword realignment buffer between the instruction fetch port and the decode/compress stage.
- Accepts fetch beats of FETCH_BYTES bytes and stores them as halfwords in a ring buffer.
- Presents one aligned instruction per handshake: a 16-bit compressed instruction or a 32-bit instruction that may straddle a beat boundary.
- Tracks the PC of each instruction and handles redirects (flush) to any halfword-aligned address.

Parameters:
- FETCH_BYTES, 4, bytes per fetch beat (4 or 8); FETCH_HW = FETCH_BYTES/2.
- DEPTH, 8, halfword entries in the ring buffer; power of two, >= 2*FETCH_HW.
- RESET_ADDR, 32'h0, PC loaded at reset.
- C_EXT, 1, 1 = RVC accepted; 0 = compressed encodings flagged illegal.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- fetch_valid  in  1  fetch beat present
- fetch_ready  out  1  buffer can accept a full beat this cycle
- fetch_data  in  8*FETCH_BYTES  beat data, lowest halfword = lowest address
- flush  in  1  redirect request
- flush_addr  in  32  redirect target; bit 0 ignored
- instr_valid  out  1  aligned instruction available
- instr_ready  in  1  consumer takes instruction
- instr  out  32  instruction; {16'b0,hw} when compressed
- instr_pc  out  32  PC of instr
- instr_comp  out  1  instr is 16-bit
- instr_illegal  out  1  compressed encoding while C_EXT=0

Behaviour:
- One clock, asynchronous active-low reset, as stated above.
- Reset state:
  - count=0, rd_ptr=0, wr_ptr=0.
  - pc_reg=RESET_ADDR, first_beat=1.
  - Resulting outputs: instr_valid=0, fetch_ready=1, instr=0, instr_pc=RESET_ADDR, instr_comp=0, instr_illegal=0.
- Storage:
  - count width is clog2(DEPTH+1).
  - Pointers wrap modulo DEPTH; no special case at wrap-around.
- Push:
  - fetch_ready = !flush && (count <= DEPTH-FETCH_HW).
  - The beat is written when fetch_valid && fetch_ready.
  - On the first beat after reset or flush, the lowest skip = pc_reg[log2(FETCH_BYTES)-1:1] halfwords are dropped and only FETCH_HW-skip halfwords are written.
  - Later beats write all FETCH_HW halfwords.
  - first_beat clears on the first accepted beat.
- Head decode (combinational from buffer):
  - h0 = buf[rd_ptr], h1 = buf[rd_ptr+1].
  - comp = (h0[1:0] != 2'b11); need = comp ? 1 : 2.
  - instr_valid = !flush && (count >= need).
  - instr = comp ? {16'b0,h0} : {h1,h0}; instr_pc = pc_reg.
  - instr_comp = comp; instr_illegal = comp && !C_EXT.
  - With instr_valid=0, instr/instr_comp/instr_illegal are don't-care. The bench checks them only when valid.
- Pop:
  - Occurs on instr_valid && instr_ready.
  - rd_ptr += need; pc_reg += 2*need; wraps at 2^32.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. Zero-latency pass-through is not provided: a pushed beat is visible at the earliest on the next cycle.
- Straddling: a 32-bit instruction whose upper halfword is not yet present holds instr_valid=0 until the next beat lands. No partial output.
- Flush (priority over push and pop in the same cycle):
  - count, rd_ptr and wr_ptr cleared.
  - pc_reg=flush_addr & ~1; first_beat=1.
  - instr_valid=0 and fetch_ready=0 in the flush cycle; any concurrent beat is discarded.
- Full: count > DEPTH-FETCH_HW deasserts fetch_ready; no overwrite is ever possible.
- Empty: count=0 gives instr_valid=0.
- count==1 with a 32-bit head gives instr_valid=0.
- Reset mid-operation: immediate return to the reset state; buffered data is lost.
- C_EXT=0: compressed encodings still pop one halfword and assert instr_illegal. Decode raises the exception.
- Latency: first instruction after flush is valid 1 cycle after the first accepted beat.

Decomposition:
- Shared package (constants/wires):
  - fetch_align_in_type and fetch_align_out_type structs.
  - Constant for the RVC length check (opcode 2'b11 = 32-bit).
  - Halfword type.
- Sub-module fetch_align_buffer: DEPTH x 16 ring storage with multi-halfword write (up to FETCH_HW per cycle at wr_ptr) and two read ports (rd_ptr, rd_ptr+1).
- Pointer, count, PC and skip logic stay in fetch_align.

Test Plan:
- Reset, flush_addr=0x100, beats 0x00130013 then 0x00A00093 (FETCH_BYTES=4) -> 32-bit instr 0x00130013 @0x100, then 0x00A00093 @0x104, instr_comp=0.
- Beat 0x4505_0505 after flush to 0x200 -> two compressed instrs 0x0505 @0x200 and 0x4505 @0x202, instr_comp=1.
- Straddle: beats 0x0093_4505, 0x0000_00A0 -> 0x4505 @pc, then 0x00A00093 @pc+2, valid only after the second beat.
- Flush to 0x302, beat 0x0505_FFFF -> low halfword dropped; first instr 0x0505 @0x302.
- Backpressure: instr_ready=0 with continuous fetch_valid (DEPTH=8, FETCH_BYTES=4) -> fetch_ready drops after 4 beats. Flush asserted the same cycle as a beat and a pop -> count=0, no output, pc=flush_addr.
- C_EXT=0, beat 0x0001_0001 -> two outputs with instr_illegal=1, pc +2 each. Async reset asserted mid-stream -> instr_valid=0 immediately, instr_pc=RESET_ADDR.
